// File: rtl/hls_fp32_add_chn_o_skid.sv
// Output-side skid stage for the fp32 adder core: 2-entry FIFO between the core's
// wait handshake (lz/vz) and a registered valid/ready stream, plus debug counters.
module hls_fp32_add_chn_o_skid #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             nvdla_core_clk,
    input  logic             nvdla_core_rstn,
    input  logic [31:0]      chn_o_rsc_z,
    input  logic             chn_o_rsc_lz,
    output logic             chn_o_rsc_vz,
    output logic [31:0]      dout_pd,
    output logic             dout_pvld,
    input  logic             dout_prdy,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] xfer_cnt,
    output logic             nan_seen
);

    logic [31:0]      mem_q [2];
    logic [31:0]      mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] xfer_cnt_q, xfer_cnt_d;
    logic             nan_seen_q, nan_seen_d;

    logic push;
    logic pop;
    logic in_is_nan;

    // Ready depends only on occupancy and reset, never on dout_prdy.
    assign chn_o_rsc_vz = nvdla_core_rstn & (cnt_q != 2'd2);
    assign push         = chn_o_rsc_lz & chn_o_rsc_vz;
    assign dout_pvld    = (cnt_q != 2'd0);
    assign dout_pd      = mem_q[rd_ptr_q];
    assign pop          = dout_pvld & dout_prdy;
    assign in_is_nan    = (chn_o_rsc_z[30:23] == 8'hFF) && (chn_o_rsc_z[22:0] != 23'd0);
    assign xfer_cnt     = xfer_cnt_q;
    assign nan_seen     = nan_seen_q;

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        xfer_cnt_d = xfer_cnt_q;
        nan_seen_d = nan_seen_q;

        if (push) begin
            mem_d[wr_ptr_q] = chn_o_rsc_z;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        cnt_d = cnt_q + {1'b0, push} - {1'b0, pop};

        // Clear beats a coincident pop; a coincident NaN push beats the clear.
        if (cnt_clr) begin
            xfer_cnt_d = '0;
        end else if (pop && (xfer_cnt_q != {CNT_W{1'b1}})) begin
            xfer_cnt_d = xfer_cnt_q + CNT_W'(1);
        end

        if (push && in_is_nan) begin
            nan_seen_d = 1'b1;
        end else if (cnt_clr) begin
            nan_seen_d = 1'b0;
        end
    end

    always_ff @(posedge nvdla_core_clk) begin
        if (!nvdla_core_rstn) begin
            mem_q[0]   <= '0;
            mem_q[1]   <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            cnt_q      <= 2'd0;
            xfer_cnt_q <= '0;
            nan_seen_q <= 1'b0;
        end else begin
            mem_q[0]   <= mem_d[0];
            mem_q[1]   <= mem_d[1];
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            cnt_q      <= cnt_d;
            xfer_cnt_q <= xfer_cnt_d;
            nan_seen_q <= nan_seen_d;
        end
    end

endmodule

// File: doc/hls_fp32_add_chn_o_skid.md
# hls_fp32_add_chn_o_skid

Output-side stage directly downstream of the fp32 adder core's output channel interface. It accepts results from the core through the core-side wait handshake, with valid on `chn_o_rsc_lz` and ready on `chn_o_rsc_vz`. It buffers them in a 2-entry skid FIFO and presents them to the NVDLA pipeline as a registered valid/ready stream. It also keeps a saturating delivered-result counter and a sticky NaN flag for debug.

## Interface
- `CNT_W`, default 16: width of the delivered-result counter.
- `nvdla_core_clk`  in  1  clock; all state updates on rising edge.
- `nvdla_core_rstn`  in  1  reset, synchronous, active-low.
- `chn_o_rsc_z`  in  32  fp32 result from the adder core output channel.
- `chn_o_rsc_lz`  in  1  core result valid.
- `chn_o_rsc_vz`  out  1  ready back to the core.
- `dout_pd`  out  32  result to the downstream pipeline (head entry).
- `dout_pvld`  out  1  downstream valid.
- `dout_prdy`  in  1  downstream ready.
- `cnt_clr`  in  1  synchronous clear of `xfer_cnt` and `nan_seen`.
- `xfer_cnt`  out  CNT_W  results delivered downstream, saturating.
- `nan_seen`  out  1  sticky; a NaN has been accepted from the core.

## Operation
- Storage: 2 entries `mem[0:1]`, 1-bit `wr_ptr` and `rd_ptr`, occupancy `cnt` in 0..2.
- `chn_o_rsc_vz = nvdla_core_rstn & (cnt != 2)`. It depends only on state and reset, with no path from `dout_prdy`.
- Push: `push = chn_o_rsc_lz & chn_o_rsc_vz`.
  - Write `mem[wr_ptr] <= chn_o_rsc_z`, then toggle `wr_ptr`.
- Pop: `dout_pvld = (cnt != 0)`, `dout_pd = mem[rd_ptr]`, `pop = dout_pvld & dout_prdy`.
  - On pop, toggle `rd_ptr`.
- `cnt` next value = `cnt + push - pop`.
  - Push and pop in the same cycle leave `cnt` unchanged.
  - Full (`cnt==2`): push impossible because `vz=0`. Pop alone takes `cnt` to 1, and `vz` rises the following cycle.
  - Empty (`cnt==0`): pop impossible. There is no combinational bypass; a pushed word first appears on `dout_pd` the next cycle.
- Pointers wrap 1→0 naturally (1-bit).
- NaN detect on push: `chn_o_rsc_z[30:23]==8'hFF && chn_o_rsc_z[22:0]!=0`. This sets `nan_seen`.
  - Infinities (mantissa 0) do not set it.
- `xfer_cnt` increments by 1 on each pop and saturates at all-ones (no wrap).
- `cnt_clr` priority:
  - `xfer_cnt` is cleared to 0 on `cnt_clr`. A pop in the same cycle is not counted (clear wins).
  - `nan_seen` is cleared on `cnt_clr` unless a NaN push occurs in the same cycle, in which case it is 1 (set wins).
- Data ordering is strict FIFO. No word is dropped or duplicated.

## Timing
- Reset: when `nvdla_core_rstn` is low at a rising edge, the next state is:
  - `cnt=0`, `wr_ptr=rd_ptr=0`, `mem[0]=mem[1]=0`, `xfer_cnt=0`, `nan_seen=0`.
  - Resulting outputs: `dout_pvld=0`, `dout_pd=0`, `vz=0`.
- While reset is low, `vz` is forced to 0 combinationally, so the core cannot transfer.
- Reset mid-operation discards buffered entries. The first cycle after reset deasserts has `vz=1` and `dout_pvld=0`.
- Latency: push at edge N gives `dout_pvld=1` with that word during cycle N+1, when `cnt` was 0.
- Throughput: 1 word/cycle sustained when `dout_prdy` is held high. Occupancy stays at 1 in steady state.
- A single-cycle `dout_prdy` stall absorbs one extra word (`cnt` goes to 2). The core is backpressured starting the cycle after the buffer fills.
- `xfer_cnt` and `nan_seen` update on the same edge as the triggering pop or push.

## Test plan
- Reset then idle:
  - Stimulus: hold `rstn=0` for 3 cycles with `lz=1` and `z=32'h3F800000`.
  - Required: `vz=0`, `dout_pvld=0`, no push. After release, `vz=1` next cycle.
- Streaming:
  - Stimulus: push 1.0, 2.0, 3.0 (`3F800000`, `40000000`, `40400000`) on consecutive cycles with `prdy=1`.
  - Required: the same sequence on `dout_pd`, each one cycle later. `xfer_cnt=3`, `cnt` never exceeds 1.
- Backpressure and full:
  - Stimulus: `prdy=0` while pushing A, B, C.
  - Required: A and B accepted, `vz=0` after the second push, C held at the core. Raising `prdy` delivers A, B, then C in order.
- Simultaneous push and pop at `cnt==1`:
  - Required: occupancy stays 1 and ordering is preserved across `wr_ptr`/`rd_ptr` wrap for 10 words.
- NaN and clear:
  - Stimulus: push `7FC00000`, then push `7F800000`.
  - Required: `nan_seen=1` after the first push; `7F800000` alone does not set it. `cnt_clr` in the same cycle as a NaN push leaves `nan_seen=1`; `cnt_clr` alone gives 0.
- Counter saturation:
  - Stimulus: with `CNT_W=4`, deliver 20 words.
  - Required: `xfer_cnt` stops at `4'hF`. `cnt_clr` coincident with a pop gives 0.
